sram_responder: RTL and testbench

- Synthesizable responder for the 16-bit external async-SRAM bus, i.e. the device end of the pins the CPU-side SRAM controller drives.
- Emulates a 64K x 16 SRAM in block RAM, sampling CE/OE/WR/UB/LB, address and data on its own fast clock.
- Used on boards with no SRAM fitted, and as the bus-accurate memory model in system simulation.
- Clock must be at least 4x the controller clock so a half-cycle WR pulse is sampled at least twice.

---
 rtl/sram_bus_pkg.sv | 33 +++
 rtl/sram_bram_be.sv | 39 +++
 rtl/sram_responder.sv | 130 +++++++++++++
 tb/tb_sram_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared definitions for the 16-bit async-SRAM bus: widths, strobe active levels,
// the responder's one-hot state encoding and the synchronized pin bundle.
package sram_bus_pkg;
    localparam int DATA_W     = 16;
    localparam int BUS_ADDR_W = 16;

    localparam logic CE_ON = 1'b1;
    localparam logic OE_ON = 1'b0;
    localparam logic WR_ON = 1'b0;
    localparam logic UB_ON = 1'b0;
    localparam logic LB_ON = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_READ  = 3'b010,
        ST_WRITE = 3'b100
    } state_t;

    typedef struct packed {
        logic                  ce;
        logic                  oe;
        logic                  wr;
        logic                  ub;
        logic                  lb;
        logic [BUS_ADDR_W-1:0] a;
        logic [DATA_W-1:0]     d;
    } bus_sample_t;

    // Pin bundle as seen with the bus completely released.
    localparam bus_sample_t BUS_IDLE = '{
        ce: ~CE_ON, oe: ~OE_ON, wr: ~WR_ON, ub: ~UB_ON, lb: ~LB_ON, a: '0, d: '0
    };
endpackage

// File: rtl/sram_bram_be.sv
// Single-port 2^ADDR_W x 16 block RAM with per-byte write enables and a registered,
// write-first read port.
module sram_bram_be
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] word;

    always_ff @(posedge clk) begin
        if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
    end

    // A read colliding with a write returns the freshly written bytes.
    always_comb begin
        word = mem[addr];
        if (we && be[0]) word[7:0]  = wdata[7:0];
        if (we && be[1]) word[15:8] = wdata[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= word;
        end
    end
endmodule

// File: rtl/sram_responder.sv
// Device end of the async-SRAM bus: samples the pins on a fast clock and serves
// reads and byte-masked writes from an internal block RAM.
module sram_responder
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WR,
    input  logic                  UB,
    input  logic                  LB,
    input  logic [BUS_ADDR_W-1:0] A,
    input  logic [DATA_W-1:0]     D_in,
    output logic [DATA_W-1:0]     D_out,
    output logic                  D_oe,
    output logic                  contention,
    output logic                  init_busy
);
    bus_sample_t       pin_sample;
    bus_sample_t       sync_q [SYNC_STAGES];
    bus_sample_t       s;

    state_t            state;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [1:0]        hold_be;
    logic [ADDR_W-1:0] init_addr;

    logic              ce_on, oe_on, wr_on, ub_on, lb_on;
    logic              rd_valid, commit;

    logic              mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign pin_sample = '{ce: CE, oe: OE, wr: WR, ub: UB, lb: LB, a: A, d: D_in};

    // Strobes, address and data share one flop chain so they stay mutually aligned.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
        end else begin
            sync_q[0] <= pin_sample;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s     = sync_q[SYNC_STAGES-1];
    assign ce_on = (s.ce == CE_ON);
    assign oe_on = (s.oe == OE_ON);
    assign wr_on = (s.wr == WR_ON);
    assign ub_on = (s.ub == UB_ON);
    assign lb_on = (s.lb == LB_ON);

    // Reads stop the moment WR joins OE, so a contended cycle never drives the bus.
    assign rd_valid = !init_busy && (state == ST_READ) && ce_on && oe_on && !wr_on;
    assign commit   = !init_busy && (state == ST_WRITE) && !wr_on;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_be    <= '0;
            D_oe       <= 1'b0;
            contention <= 1'b0;
            init_addr  <= '0;
            init_busy  <= (INIT_ZERO != 0);
        end else if (init_busy) begin
            init_addr <= init_addr + 1'b1;
            if (&init_addr) init_busy <= 1'b0;
        end else begin
            D_oe <= rd_valid;
            if (ce_on && oe_on && wr_on) contention <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ce_on && wr_on)      state <= ST_WRITE;
                    else if (ce_on && oe_on) state <= ST_READ;
                end
                ST_READ: begin
                    if (wr_on)                state <= ST_WRITE;
                    else if (!oe_on || !ce_on) state <= ST_IDLE;
                end
                ST_WRITE: begin
                    hold_addr <= s.a[ADDR_W-1:0];
                    hold_data <= s.d;
                    hold_be   <= {ub_on, lb_on};
                    if (!wr_on || !ce_on) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = s.a[ADDR_W-1:0];
        mem_wdata = hold_data;
        if (init_busy) begin
            mem_we    = 1'b1;
            mem_be    = 2'b11;
            mem_addr  = init_addr;
            mem_wdata = '0;
        end else if (commit) begin
            mem_we    = 1'b1;
            mem_be    = hold_be;
            mem_addr  = hold_addr;
        end
    end

    sram_bram_be #(
        .ADDR_W(ADDR_W)
    ) u_bram (
        .clk  (CLK),
        .rst_n(RESET_N),
        .we   (mem_we),
        .be   (mem_be),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .re   (rd_valid),
        .rdata(D_out)
    );
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a 64K init-zero instance and an 8-bit-address,
// no-init instance share one bus; each has its own reset.
module tb_sram_responder;
    typedef struct {
        logic        is_write;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ub;
        logic        lb;
        int          pulse;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n;
    logic        ce, oe, wr, ub, lb;
    logic [15:0] addr, din;
    logic [15:0] dout0, dout1;
    logic        doe0, doe1, cont0, cont1, busy0, busy1;
    logic        use_small;
    logic        cur_doe;
    logic [15:0] cur_dout;
    int          checks = 0;
    int          passes = 0;
    vec_t        vecs[14];

    always #5 clk = ~clk;

    assign cur_doe  = use_small ? doe1 : doe0;
    assign cur_dout = use_small ? dout1 : dout0;

    sram_responder #(.ADDR_W(16), .SYNC_STAGES(2), .INIT_ZERO(1)) dut0 (
        .CLK(clk), .RESET_N(rst0_n), .CE(ce), .OE(oe), .WR(wr), .UB(ub), .LB(lb),
        .A(addr), .D_in(din), .D_out(dout0), .D_oe(doe0), .contention(cont0),
        .init_busy(busy0)
    );

    sram_responder #(.ADDR_W(8), .SYNC_STAGES(2), .INIT_ZERO(0)) dut1 (
        .CLK(clk), .RESET_N(rst1_n), .CE(ce), .OE(oe), .WR(wr), .UB(ub), .LB(lb),
        .A(addr), .D_in(din), .D_out(dout1), .D_oe(doe1), .contention(cont1),
        .init_busy(busy1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic busIdle();
        ce = 1'b0;
        oe = 1'b1;
        wr = 1'b1;
        ub = 1'b1;
        lb = 1'b1;
    endtask

    task automatic writeWord(input logic [15:0] a, input logic [15:0] d,
                             input logic u, input logic l, input int pulse);
        @(negedge clk);
        ce = 1'b1; addr = a; din = d; ub = u; lb = l; oe = 1'b1; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        repeat (pulse) @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        busIdle();
        repeat (4) @(negedge clk);
    endtask

    // OE falls between edges; D_oe must appear after exactly SYNC_STAGES+2 = 4 edges.
    task automatic readWord(input logic [15:0] a, input logic [15:0] expected, input string name);
        int  edges;
        logic got;
        @(negedge clk);
        ce = 1'b1; addr = a; oe = 1'b1; wr = 1'b1;
        @(negedge clk);
        oe = 1'b0;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 12) begin
            @(posedge clk);
            #1;
            edges++;
            got = cur_doe;
        end
        checkOutput({name, " latency"}, edges, 4);
        checkOutput({name, " data"}, cur_dout, expected);
        @(negedge clk);
        oe = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput({name, " doe released"}, cur_doe, 1'b0);
        checkOutput({name, " dout held"}, cur_dout, expected);
        busIdle();
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.is_write) writeWord(v.addr, v.data, v.ub, v.lb, v.pulse);
        else readWord(v.addr, v.data, $sformatf("vec%0d", idx));
    endtask

    initial begin
        int   init_cycles;
        int   n;
        logic doe_in_init;
        logic dropped;
        logic seen;
        logic [15:0] d2, d3;

        use_small = 1'b0;
        busIdle();
        addr   = '0;
        din    = '0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;

        vecs[0]  = '{1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 16'h0012, 16'hBEEF, 1'b1, 1'b1, 0};
        vecs[2]  = '{1'b1, 16'h0012, 16'h00AA, 1'b1, 1'b0, 3};
        vecs[3]  = '{1'b0, 16'h0012, 16'hBEAA, 1'b1, 1'b1, 0};
        vecs[4]  = '{1'b1, 16'h0012, 16'h1100, 1'b0, 1'b1, 6};
        vecs[5]  = '{1'b0, 16'h0012, 16'h11AA, 1'b1, 1'b1, 0};
        vecs[6]  = '{1'b1, 16'h0012, 16'h7777, 1'b1, 1'b1, 2};
        vecs[7]  = '{1'b0, 16'h0012, 16'h11AA, 1'b1, 1'b1, 0};
        vecs[8]  = '{1'b0, 16'h4000, 16'h0000, 1'b1, 1'b1, 0};
        vecs[9]  = '{1'b1, 16'hFFFF, 16'hCAFE, 1'b0, 1'b0, 4};
        vecs[10] = '{1'b0, 16'hFFFF, 16'hCAFE, 1'b1, 1'b1, 0};
        vecs[11] = '{1'b1, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 2};
        vecs[12] = '{1'b0, 16'h0000, 16'h0F0F, 1'b1, 1'b1, 0};
        vecs[13] = '{1'b0, 16'hFFFF, 16'hCAFE, 1'b1, 1'b1, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset doe0", doe0, 1'b0);
        checkOutput("reset dout0", dout0, 16'h0000);
        checkOutput("reset contention0", cont0, 1'b0);
        checkOutput("reset init_busy0", busy0, 1'b1);
        checkOutput("reset init_busy1", busy1, 1'b0);
        checkOutput("reset doe1", doe1, 1'b0);

        rst0_n      = 1'b1;
        rst1_n      = 1'b1;
        init_cycles = 0;
        doe_in_init = 1'b0;

        fork
            begin
                while (busy0 && init_cycles < 70000) begin
                    @(posedge clk);
                    #1;
                    init_cycles++;
                    if (doe0) doe_in_init = 1'b1;
                end
            end
            begin
                use_small = 1'b1;
                repeat (3) @(negedge clk);
                writeWord(16'h0112, 16'h1234, 1'b0, 1'b0, 3);
                readWord(16'h0012, 16'h1234, "wrap read");

                @(negedge clk);
                ce = 1'b1; addr = 16'h0012;
                @(negedge clk);
                oe = 1'b0;
                n = 0;
                while (!doe1 && n < 12) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checkOutput("doe1 before reset", doe1, 1'b1);
                #2 rst1_n = 1'b0;
                #1;
                checkOutput("doe1 async reset", doe1, 1'b0);
                checkOutput("dout1 async reset", dout1, 16'h0000);
                busIdle();
                repeat (2) @(negedge clk);
                rst1_n = 1'b1;
                repeat (3) @(negedge clk);

                ce = 1'b1; addr = 16'h0012; din = 16'hDEAD; ub = 1'b0; lb = 1'b0;
                @(negedge clk);
                wr = 1'b0;
                repeat (4) @(negedge clk);
                rst1_n = 1'b0;
                @(negedge clk);
                busIdle();
                repeat (2) @(negedge clk);
                rst1_n = 1'b1;
                repeat (4) @(negedge clk);
                readWord(16'h0012, 16'h1234, "reset-aborted write");
                checkOutput("contention1 clear", cont1, 1'b0);
            end
        join
        use_small = 1'b0;

        checkOutput("init_busy cycles", init_cycles, 65536);
        checkOutput("doe0 during init", doe_in_init, 1'b0);
        checkOutput("init_busy0 after init", busy0, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        writeWord(16'h0020, 16'h2222, 1'b0, 1'b0, 2);
        writeWord(16'h0021, 16'h3333, 1'b0, 1'b0, 2);
        @(negedge clk);
        ce = 1'b1; addr = 16'h0020;
        @(negedge clk);
        oe = 1'b0;
        n = 0;
        while (!doe0 && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("addr change first data", dout0, 16'h2222);
        @(negedge clk);
        addr    = 16'h0021;
        dropped = 1'b0;
        d2      = '0;
        d3      = '0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (!doe0) dropped = 1'b1;
            if (k == 2) d2 = dout0;
            if (k == 3) d3 = dout0;
        end
        checkOutput("addr change edge2 data", d2, 16'h2222);
        checkOutput("addr change edge3 data", d3, 16'h3333);
        checkOutput("addr change doe dropped", dropped, 1'b0);
        @(negedge clk);
        oe = 1'b1;
        repeat (4) @(negedge clk);
        busIdle();
        repeat (2) @(negedge clk);

        writeWord(16'h0040, 16'h1357, 1'b0, 1'b0, 2);
        @(negedge clk);
        ce = 1'b1; addr = 16'h0040; din = 16'h9999; ub = 1'b0; lb = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        busIdle();
        repeat (4) @(negedge clk);
        readWord(16'h0040, 16'h1357, "CE-aborted write");

        checkOutput("contention0 before", cont0, 1'b0);
        @(negedge clk);
        ce = 1'b1; addr = 16'h0003; din = 16'h5555; ub = 1'b0; lb = 1'b0;
        @(negedge clk);
        oe   = 1'b0;
        wr   = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (doe0) seen = 1'b1;
        end
        @(negedge clk);
        oe = 1'b1;
        wr = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (doe0) seen = 1'b1;
        end
        @(negedge clk);
        busIdle();
        repeat (4) @(negedge clk);
        checkOutput("contention doe stayed low", seen, 1'b0);
        checkOutput("contention set", cont0, 1'b1);
        readWord(16'h0003, 16'h5555, "contention readback");
        checkOutput("contention sticky", cont0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
